if_pc_redirect: RTL and testbench

- PC generation plus IF/ID pipeline register for the 5-stage RV32I core.
- Consumes the ID-stage branch decision (Branch, SB_type) and jump controls, and computes the next fetch PC.
- Drives the instruction-memory address, and on any taken redirect squashes the wrong-path instruction sitting in IF.
- Also counts taken redirects and flags misaligned targets.

---
 rtl/if_pc_redirect_pkg.sv | 25 ++
 rtl/if_pc_redirect_next_pc_sel.sv | 40 ++++
 rtl/if_pc_redirect.sv | 159 +++++++++++++++
 tb/tb_if_pc_redirect.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/if_pc_redirect_pkg.sv
// ---------------------------------------------------------------------------
// if_pc_redirect_pkg
// Shared definitions for the fetch-stage PC generator of the 5-stage RV32I
// core: default reset PC, the NOP injected on squash, the fetch step, the
// JALR target mask and the two-state fetch FSM encoding.
// ---------------------------------------------------------------------------
package if_pc_redirect_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;  // addi x0,x0,0
    localparam logic [31:0] PC_STEP           = 32'h0000_0004;
    localparam logic [31:0] JALR_MASK         = 32'hFFFF_FFFE;

    // BOOT spends exactly one cycle issuing the first fetch; RUN is normal flow.
    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } fetch_state_e;

    // A fetch target is misaligned when it is not on a 4-byte boundary.
    function automatic logic is_misaligned(input logic [31:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/if_pc_redirect_next_pc_sel.sv
// ---------------------------------------------------------------------------
// next_pc_sel
// Combinational next-PC arithmetic for the fetch stage.
//   pc_if     : current fetch address
//   if_id_pc  : PC of the instruction in ID (base for branch / JAL targets)
//   id_imm    : sign-extended byte offset of the ID instruction
//   rs1_data  : forwarded rs1 value (base for JALR)
//   jalr      : ID instruction is JALR; selects the masked rs1+imm target
//   seq_pc    : sequential fetch address, pc_if + 4
//   target    : redirect target; all sums are 32-bit modulo
// ---------------------------------------------------------------------------
module next_pc_sel
    import if_pc_redirect_pkg::*;
(
    input  logic [31:0] pc_if,
    input  logic [31:0] if_id_pc,
    input  logic [31:0] id_imm,
    input  logic [31:0] rs1_data,
    input  logic        jalr,
    output logic [31:0] seq_pc,
    output logic [31:0] target
);

    logic [31:0] jalr_sum_s;
    logic [31:0] rel_sum_s;

    // Sequential and redirect target arithmetic; JALR takes precedence over
    // the PC-relative form so a simultaneous JAL+JALR lands on the JALR target.
    always_comb begin
        seq_pc     = pc_if + PC_STEP;
        jalr_sum_s = rs1_data + id_imm;
        rel_sum_s  = if_id_pc + id_imm;
        if (jalr) begin
            target = jalr_sum_s & JALR_MASK;
        end else begin
            target = rel_sum_s;
        end
    end

endmodule

// File: rtl/if_pc_redirect.sv
// ---------------------------------------------------------------------------
// if_pc_redirect
// PC generation and IF/ID pipeline register for the 5-stage RV32I core.
// Takes the ID-stage branch/jump decision, steers the fetch PC, squashes the
// wrong-path fetch on a taken redirect, counts redirects and records any
// misaligned redirect target.
//
// Ports
//   clk, rst_n        : clock (rising edge), asynchronous active-low reset
//   stall             : freezes PC, IF/ID and the redirect counter
//   Branch, SB_type   : branch-test result and "ID holds a conditional branch"
//   jal, jalr         : ID instruction is JAL / JALR
//   id_imm            : sign-extended byte offset of the ID instruction
//   rs1Data           : forwarded rs1 value in ID
//   imem_instr        : instruction word read combinationally at pc_if
//   pc_if             : current fetch address
//   if_id_pc/instr/valid : contents of the IF/ID register
//   redirect          : combinational, a redirect is taken this cycle
//   misalign          : sticky, some redirect target had bits [1:0] != 0
//   redirect_cnt      : number of taken redirects, wraps at 2^32
// ---------------------------------------------------------------------------
module if_pc_redirect
    import if_pc_redirect_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        Branch,
    input  logic        SB_type,
    input  logic        jal,
    input  logic        jalr,
    input  logic [31:0] id_imm,
    input  logic [31:0] rs1Data,
    input  logic [31:0] imem_instr,
    output logic [31:0] pc_if,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_instr,
    output logic        if_id_valid,
    output logic        redirect,
    output logic        misalign,
    output logic [31:0] redirect_cnt
);

    fetch_state_e state_r;
    fetch_state_e state_nxt_s;

    logic [31:0] pc_r,         pc_nxt_s;
    logic [31:0] ifid_pc_r,    ifid_pc_nxt_s;
    logic [31:0] ifid_instr_r, ifid_instr_nxt_s;
    logic        ifid_valid_r, ifid_valid_nxt_s;
    logic        misalign_r,   misalign_nxt_s;
    logic [31:0] cnt_r,        cnt_nxt_s;

    logic [31:0] seq_pc_s;
    logic [31:0] target_s;
    logic        take_s;
    logic        redirect_s;

    next_pc_sel u_next_pc_sel (
        .pc_if    (pc_r),
        .if_id_pc (ifid_pc_r),
        .id_imm   (id_imm),
        .rs1_data (rs1Data),
        .jalr     (jalr),
        .seq_pc   (seq_pc_s),
        .target   (target_s)
    );

    // Redirect qualification: Branch is only meaningful with SB_type because
    // the branch tester holds its last result otherwise, and nothing in an
    // invalid (squashed) IF/ID slot may redirect.
    always_comb begin
        take_s = ifid_valid_r & ~stall & ((SB_type & Branch) | jal | jalr);
        if (state_r == RUN) begin
            redirect_s = take_s;
        end else begin
            redirect_s = 1'b0;
        end
    end

    // Next-state and next-register values for the fetch FSM.
    always_comb begin
        state_nxt_s      = state_r;
        pc_nxt_s         = pc_r;
        ifid_pc_nxt_s    = ifid_pc_r;
        ifid_instr_nxt_s = ifid_instr_r;
        ifid_valid_nxt_s = ifid_valid_r;
        misalign_nxt_s   = misalign_r;
        cnt_nxt_s        = cnt_r;
        case (state_r)
            BOOT: begin
                // First fetch is presented at RESET_PC; nothing is latched
                // and stall has no effect here.
                state_nxt_s = RUN;
            end
            RUN: begin
                state_nxt_s = RUN;
                if (stall) begin
                    // Hold everything; a pending redirect is re-evaluated
                    // once the stall drops.
                    pc_nxt_s = pc_r;
                end else if (take_s) begin
                    pc_nxt_s         = target_s;
                    ifid_pc_nxt_s    = pc_r;
                    ifid_instr_nxt_s = NOP_INSTR;
                    ifid_valid_nxt_s = 1'b0;
                    cnt_nxt_s        = cnt_r + 32'd1;
                    if (is_misaligned(target_s)) begin
                        misalign_nxt_s = 1'b1;
                    end else begin
                        misalign_nxt_s = misalign_r;
                    end
                end else begin
                    pc_nxt_s         = seq_pc_s;
                    ifid_pc_nxt_s    = pc_r;
                    ifid_instr_nxt_s = imem_instr;
                    ifid_valid_nxt_s = 1'b1;
                end
            end
            default: begin
                state_nxt_s = BOOT;
            end
        endcase
    end

    // FSM state and fetch-path registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= BOOT;
            pc_r         <= RESET_PC;
            ifid_pc_r    <= 32'h0000_0000;
            ifid_instr_r <= NOP_INSTR;
            ifid_valid_r <= 1'b0;
            misalign_r   <= 1'b0;
            cnt_r        <= 32'h0000_0000;
        end else begin
            state_r      <= state_nxt_s;
            pc_r         <= pc_nxt_s;
            ifid_pc_r    <= ifid_pc_nxt_s;
            ifid_instr_r <= ifid_instr_nxt_s;
            ifid_valid_r <= ifid_valid_nxt_s;
            misalign_r   <= misalign_nxt_s;
            cnt_r        <= cnt_nxt_s;
        end
    end

    assign pc_if        = pc_r;
    assign if_id_pc     = ifid_pc_r;
    assign if_id_instr  = ifid_instr_r;
    assign if_id_valid  = ifid_valid_r;
    assign misalign     = misalign_r;
    assign redirect_cnt = cnt_r;
    assign redirect     = redirect_s;

endmodule

// File: tb/tb_if_pc_redirect.sv
// ---------------------------------------------------------------------------
// tb_if_pc_redirect
// Directed bench for if_pc_redirect. A reference model of the fetch stage,
// written directly from the redirect rules, is compared against the DUT on
// every falling edge; literal expectations pin key points of each scenario.
// ---------------------------------------------------------------------------
module tb_if_pc_redirect;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        Branch;
    logic        SB_type;
    logic        jal;
    logic        jalr;
    logic [31:0] id_imm;
    logic [31:0] rs1Data;
    logic [31:0] imem_instr;
    logic [31:0] pc_if;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
    logic        redirect;
    logic        misalign;
    logic [31:0] redirect_cnt;

    int checks;
    int errors;

    if_pc_redirect dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .Branch       (Branch),
        .SB_type      (SB_type),
        .jal          (jal),
        .jalr         (jalr),
        .id_imm       (id_imm),
        .rs1Data      (rs1Data),
        .imem_instr   (imem_instr),
        .pc_if        (pc_if),
        .if_id_pc     (if_id_pc),
        .if_id_instr  (if_id_instr),
        .if_id_valid  (if_id_valid),
        .redirect     (redirect),
        .misalign     (misalign),
        .redirect_cnt (redirect_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory contents: a fixed word at 0, address-tagged elsewhere.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0000) return 32'h0050_0093;
        return {a[19:0], 12'h093};
    endfunction

    assign imem_instr = mem_word(pc_if);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic        m_boot;
    logic [31:0] m_pc, m_ipc, m_instr, m_cnt;
    logic        m_valid, m_mis;

    function automatic logic m_take();
        return !m_boot && m_valid && !stall && ((SB_type && Branch) || jal || jalr);
    endfunction

    function automatic logic [31:0] m_target();
        logic [31:0] t;
        if (jalr) begin
            t = rs1Data + id_imm;
            t[0] = 1'b0;
        end else begin
            t = m_ipc + id_imm;
        end
        return t;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_boot <= 1'b1; m_pc <= 32'h0; m_ipc <= 32'h0; m_instr <= 32'h13;
            m_valid <= 1'b0; m_mis <= 1'b0; m_cnt <= 32'h0;
        end else if (m_boot) begin
            m_boot <= 1'b0;
        end else if (m_take()) begin
            m_pc <= m_target(); m_ipc <= m_pc; m_instr <= 32'h13; m_valid <= 1'b0;
            m_cnt <= m_cnt + 32'd1;
            if (m_target() % 4 != 0) m_mis <= 1'b1;
        end else if (!stall) begin
            m_pc <= m_pc + 32'd4; m_ipc <= m_pc; m_instr <= mem_word(m_pc); m_valid <= 1'b1;
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        chk("pc_if", pc_if, m_pc);
        chk("if_id_pc", if_id_pc, m_ipc);
        chk("if_id_instr", if_id_instr, m_instr);
        chk("if_id_valid", {31'd0, if_id_valid}, {31'd0, m_valid});
        chk("redirect", {31'd0, redirect}, {31'd0, m_take()});
        chk("misalign", {31'd0, misalign}, {31'd0, m_mis});
        chk("redirect_cnt", redirect_cnt, m_cnt);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        stall = 1'b0; Branch = 1'b0; SB_type = 1'b0; jal = 1'b0; jalr = 1'b0;
        id_imm = 32'h0; rs1Data = 32'h0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        clr();
        #12 rst_n = 1'b1;

        // Reset release: BOOT edge then first real fetch.
        tick();
        chk("boot_pc", pc_if, 32'h0);
        chk("boot_valid", {31'd0, if_id_valid}, 32'h0);
        tick();
        chk("run_pc", pc_if, 32'h4);
        chk("run_instr", if_id_instr, 32'h0050_0093);
        chk("run_ifid_pc", if_id_pc, 32'h0);
        chk("run_valid", {31'd0, if_id_valid}, 32'h1);
        repeat (4) tick();
        chk("pre_beq_ifid_pc", if_id_pc, 32'h10);

        // Taken BEQ.
        SB_type = 1'b1; Branch = 1'b1; id_imm = 32'h20;
        #1 chk("beq_redirect", {31'd0, redirect}, 32'h1);
        tick();
        clr();
        chk("beq_pc", pc_if, 32'h30);
        chk("beq_instr", if_id_instr, 32'h13);
        chk("beq_valid", {31'd0, if_id_valid}, 32'h0);
        chk("beq_cnt", redirect_cnt, 32'h1);
        tick();

        // Stale Branch without SB_type.
        Branch = 1'b1;
        #1 chk("stale_redirect", {31'd0, redirect}, 32'h0);
        tick();
        clr();
        chk("stale_pc", pc_if, 32'h38);
        chk("stale_cnt", redirect_cnt, 32'h1);

        // Stall holds a pending JAL for three edges.
        stall = 1'b1; jal = 1'b1; id_imm = 32'h100;
        repeat (3) tick();
        chk("stall_pc", pc_if, 32'h38);
        chk("stall_ifid_pc", if_id_pc, 32'h34);
        stall = 1'b0;
        #1 chk("unstall_redirect", {31'd0, redirect}, 32'h1);
        tick();
        clr();
        chk("unstall_pc", pc_if, 32'h134);
        chk("unstall_cnt", redirect_cnt, 32'h2);
        tick();

        // JALR with odd sum clears bit 0.
        jalr = 1'b1; rs1Data = 32'h1001; id_imm = 32'h4;
        tick();
        clr();
        chk("jalr_pc", pc_if, 32'h1004);
        chk("jalr_mis", {31'd0, misalign}, 32'h0);
        tick();

        // JAL to a misaligned target; held one more edge while IF/ID is invalid.
        jal = 1'b1; id_imm = 32'h6;
        tick();
        chk("jal_mis_pc", pc_if, 32'h100A);
        chk("jal_mis_flag", {31'd0, misalign}, 32'h1);
        tick();
        clr();
        chk("jal_invalid_ignored_cnt", redirect_cnt, 32'h4);
        chk("jal_invalid_pc", pc_if, 32'h100E);

        // JAL and JALR together: JALR target, counted once.
        jal = 1'b1; jalr = 1'b1; rs1Data = 32'h2000; id_imm = 32'h8;
        tick();
        clr();
        chk("both_pc", pc_if, 32'h2008);
        chk("both_cnt", redirect_cnt, 32'h5);
        chk("mis_sticky", {31'd0, misalign}, 32'h1);
        tick();

        // Target arithmetic wraps silently.
        jalr = 1'b1; rs1Data = 32'hFFFF_FFF0; id_imm = 32'h20;
        tick();
        clr();
        chk("wrap_pc", pc_if, 32'h10);
        tick();

        // Asynchronous reset between edges.
        #2 rst_n = 1'b0;
        #1;
        chk("areset_pc", pc_if, 32'h0);
        chk("areset_instr", if_id_instr, 32'h13);
        chk("areset_valid", {31'd0, if_id_valid}, 32'h0);
        chk("areset_cnt", redirect_cnt, 32'h0);
        chk("areset_mis", {31'd0, misalign}, 32'h0);
        @(negedge clk);
        #2 rst_n = 1'b1;

        // Stall is ignored in BOOT but honoured in RUN.
        stall = 1'b1;
        tick();
        chk("boot_stall_pc", pc_if, 32'h0);
        tick();
        chk("run_stall_valid", {31'd0, if_id_valid}, 32'h0);
        stall = 1'b0;
        tick();
        chk("rerun_pc", pc_if, 32'h4);
        chk("rerun_instr", if_id_instr, 32'h0050_0093);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time bound.
    initial begin
        #20000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
